fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that consumes the branch/jump redirect (PC_sel, jPC) produced by the execute stage. It owns the PC and issues in-order requests to instruction memory over a valid/ready request channel. Returned words go into a small prefetch buffer, which feeds decode through the IF/ID pipe_en stall. On a redirect it discards stale in-flight responses and flushes the buffer.

Parameters:
N, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, prefetch buffer entries; also the maximum number of outstanding requests plus buffered words (power of 2, at least 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
pipe_en  in  1  decode accepts the head instruction this cycle (IF/ID enable)
PC_sel  in  1  redirect request from EX/MEM, single-cycle pulse
jPC  in  N  redirect target from EX/MEM
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request
imem_addr  out  N  fetch address, equal to the PC register
imem_rsp_valid  in  1  response word valid; responses arrive in order, at least 1 cycle after acceptance
imem_rsp_data  in  N  instruction word
instr_out  out  N  head instruction to decode
PC_out  out  N  address of instr_out
NPC4_out  out  N  PC_out + 4, modulo 2^N
valid_out  out  1  instr_out/PC_out are valid

Behaviour:
- Reset, synchronous and active-high: PC=RESET_PC; buffer empty; outstanding=0; discard=0. Outputs are valid_out=0, imem_req_valid=0 in the reset cycle, and instr_out/PC_out/NPC4_out=0. The instruction memory shares rst, so no response for a pre-reset request is returned.
- Issue: imem_req_valid = !rst && !PC_sel && (outstanding + count < DEPTH). On valid&&ready: PC <= PC+4 (wrap modulo 2^N) and outstanding++. Record the PC with the request in an in-order address queue of DEPTH entries.
- Response with discard==0: push {data, addr queue head} into the buffer and outstanding--. The buffer can never overflow by construction. Assert if it is pushed while full.
- Response with discard>0: drop the word, discard-- and outstanding--.
- Decode side: valid_out = count>0. instr_out/PC_out show the head entry. Pop when valid_out&&pipe_en. When pipe_en=0 the outputs hold stable.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Redirect (PC_sel=1), all effective in the same cycle:
  - PC <= {jPC[N-1:2],2'b00}, with the low bits forced to zero.
  - Buffer flushed, so valid_out=0 the next cycle.
  - discard <= outstanding minus any response arriving this cycle (that response is dropped).
  - No request is issued this cycle.
  - A concurrent pop is ignored.
- First request to the new target: issued at the earliest the cycle after PC_sel.
- States: RUN (discard==0) and DRAIN (discard>0).
  - Requests may issue in DRAIN.
  - The responses to the new requests queue behind the discarded ones, and ordering keeps them correct.
  - DRAIN->RUN when the last stale response is dropped.
  - A redirect in DRAIN reloads discard with the current outstanding count, again net of a response arriving that cycle.
- Back-to-back redirects: the last target wins, and each one flushes.
- Latency: the instruction appears on valid_out the cycle after imem_rsp_valid.
- Fetch is sequential: the redirect comes from EX, so wrong-path words already in IF/ID are squashed by the existing pipeline flush, not by this block.

Test Plan:
- Reset with RESET_PC=0, ready=1, 1-cycle memory, pipe_en=1 -> addresses 0,4,8,…. valid_out rises 2 cycles after reset release, and PC_out steps by 4 each cycle with NPC4_out=PC_out+4.
- pipe_en=0 for 5 cycles -> buffer fills to DEPTH=2; imem_req_valid drops once outstanding+count=2; instr_out holds the same word; no request is lost or duplicated when pipe_en returns to 1.
- Redirect with 2 requests outstanding: PC_sel=1, jPC=0x100 -> the next 2 responses are dropped; the first valid_out after that has PC_out=0x100, NPC4_out=0x104.
- Redirect in the same cycle as a response: that word never appears on instr_out.
- Two redirects: PC_sel to 0x200, then the next cycle to 0x300 while in DRAIN -> no 0x200 instruction is delivered; the next delivered PC_out is 0x300.
- imem_req_ready toggling 1,0,0,1 with 3-cycle response latency -> the delivered order is strictly sequential from 0, with no gaps.
- PC=0xFFFF_FFFC -> the next address wraps to 0x0000_0000.
- Unaligned jPC=0x102 -> fetch restarts at 0x100.
- rst asserted mid-stream -> all outputs return to their reset values next cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers returned words for decode.
// Latency: a word is on valid_out the cycle after imem_rsp_valid; requests throttle on outstanding + buffered < DEPTH.
module fetch_unit #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pipe_en,
  input  logic         PC_sel,
  input  logic [N-1:0] jPC,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [N-1:0] imem_rsp_data,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] PC_out,
  output logic [N-1:0] NPC4_out,
  output logic         valid_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t         state;
  logic [N-1:0]   pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  count;
  logic [CW-1:0]  discard;
  logic [CW-1:0]  next_discard;
  logic [CW:0]    inflight;

  logic [N-1:0]   aq_mem    [DEPTH];
  logic [AW-1:0]  aq_wr;
  logic [AW-1:0]  aq_rd;
  logic [N-1:0]   buf_instr [DEPTH];
  logic [N-1:0]   buf_pc    [DEPTH];
  logic [AW-1:0]  buf_wr;
  logic [AW-1:0]  buf_rd;

  logic issue;
  logic push;
  logic pop;

  assign inflight       = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = !rst && !PC_sel && (inflight < (CW+1)'(DEPTH));
  assign imem_addr      = pc;
  assign issue          = imem_req_valid && imem_req_ready;

  // A response arriving with a redirect is stale by definition, so it is never pushed.
  assign push      = imem_rsp_valid && !PC_sel && (state == RUN);
  assign valid_out = !rst && (count != '0);
  assign pop       = valid_out && pipe_en && !PC_sel;

  assign instr_out = valid_out ? buf_instr[buf_rd] : '0;
  assign PC_out    = valid_out ? buf_pc[buf_rd] : '0;
  assign NPC4_out  = valid_out ? (buf_pc[buf_rd] + N'(4)) : '0;

  always_comb begin
    next_discard = discard;
    if (PC_sel)
      next_discard = outstanding - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && (state == DRAIN))
      next_discard = discard - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      discard     <= '0;
      state       <= RUN;
      aq_wr       <= '0;
      aq_rd       <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
    end else begin
      assert (!(push && (count == CW'(DEPTH))));

      if (PC_sel)
        pc <= jPC & ~N'(3);
      else if (issue)
        pc <= pc + N'(4);

      if (issue)
        aq_wr <= aq_wr + AW'(1);
      if (imem_rsp_valid)
        aq_rd <= aq_rd + AW'(1);
      outstanding <= outstanding + CW'(issue) - CW'(imem_rsp_valid);

      discard <= next_discard;
      state   <= (next_discard != '0) ? DRAIN : RUN;

      if (PC_sel) begin
        count  <= '0;
        buf_rd <= buf_wr;
      end else begin
        if (push)
          buf_wr <= buf_wr + AW'(1);
        if (pop)
          buf_rd <= buf_rd + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers and counters above.
  always_ff @(posedge clk) begin
    if (issue)
      aq_mem[aq_wr] <= pc;
    if (push) begin
      buf_instr[buf_wr] <= imem_rsp_data;
      buf_pc[buf_wr]    <= aq_mem[aq_rd];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder plus a queue-based model of buffered and stale words.
module tb_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_en = 1'b1;
  logic        PC_sel = 1'b0;
  logic [31:0] jPC = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] instr_out;
  logic [31:0] PC_out;
  logic [31:0] NPC4_out;
  logic        valid_out;

  fetch_unit #(.N(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pipe_en(pipe_en), .PC_sel(PC_sel), .jPC(jPC),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_out(instr_out), .PC_out(PC_out), .NPC4_out(NPC4_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int rdy_mode = 0;
  int pe_mode = 0;
  int stale = 0;
  int n_deliv = 0;
  logic pe_fixed = 1'b1;
  logic [3:0] rdy_pat = 4'b1001;

  logic [31:0] mq_addr[$];
  logic [31:0] mq_dat[$];
  int          mq_due[$];
  logic [31:0] bufq_pc[$];
  logic [31:0] bufq_dat[$];
  logic [31:0] deliv_q[$];
  logic [31:0] issue_pc = RST_PC;
  logic [31:0] exp_next = RST_PC;

  // One clock: check DUT against the model at negedge, advance the model, drive the next cycle.
  task automatic cycle();
    logic exp_rv, exp_vo, acc, pop_m;
    logic [31:0] a, d, tgt;
    @(negedge clk);
    if (rst) begin
      total++;
      if (valid_out !== 1'b0 || imem_req_valid !== 1'b0) begin
        bad++; $display("FAIL rst_ctrl: valid_out=%b req_valid=%b want 0 0", valid_out, imem_req_valid);
      end
      total++;
      if (instr_out !== 32'd0 || PC_out !== 32'd0 || NPC4_out !== 32'd0) begin
        bad++; $display("FAIL rst_data: instr=%h pc=%h npc4=%h want all 0", instr_out, PC_out, NPC4_out);
      end
      mq_addr.delete(); mq_dat.delete(); mq_due.delete();
      bufq_pc.delete(); bufq_dat.delete();
      stale = 0; issue_pc = RST_PC; exp_next = RST_PC;
    end else begin
      exp_rv = !PC_sel && ((mq_addr.size() + bufq_pc.size()) < DEPTH);
      total++;
      if (imem_req_valid !== exp_rv) begin
        bad++; $display("FAIL req_valid: got %b want %b (cyc %0d)", imem_req_valid, exp_rv, cyc);
      end
      if (exp_rv) begin
        total++;
        if (imem_addr !== issue_pc) begin
          bad++; $display("FAIL req_addr: got %h want %h (cyc %0d)", imem_addr, issue_pc, cyc);
        end
      end
      exp_vo = bufq_pc.size() > 0;
      total++;
      if (valid_out !== exp_vo) begin
        bad++; $display("FAIL valid_out: got %b want %b (cyc %0d)", valid_out, exp_vo, cyc);
      end
      if (exp_vo) begin
        total++;
        if (PC_out !== bufq_pc[0] || instr_out !== bufq_dat[0] || NPC4_out !== bufq_pc[0] + 32'd4) begin
          bad++; $display("FAIL head: pc=%h instr=%h npc4=%h want pc=%h instr=%h (cyc %0d)",
                          PC_out, instr_out, NPC4_out, bufq_pc[0], bufq_dat[0], cyc);
        end
      end
      acc   = imem_req_valid && imem_req_ready;
      pop_m = valid_out && pipe_en && !PC_sel;
      if (pop_m) begin
        total++;
        if (PC_out !== exp_next) begin
          bad++; $display("FAIL seq_pc: delivered %h want %h (cyc %0d)", PC_out, exp_next, cyc);
        end
        exp_next = exp_next + 32'd4;
        n_deliv++;
        deliv_q.push_back(PC_out);
        if (bufq_pc.size() > 0) begin
          void'(bufq_pc.pop_front()); void'(bufq_dat.pop_front());
        end
      end
      if (imem_rsp_valid && mq_addr.size() > 0) begin
        a = mq_addr.pop_front(); d = mq_dat.pop_front(); void'(mq_due.pop_front());
        if (stale > 0) stale--;
        else if (!PC_sel) begin bufq_pc.push_back(a); bufq_dat.push_back(d); end
      end
      if (PC_sel) begin
        tgt = jPC & 32'hFFFF_FFFC;
        bufq_pc.delete(); bufq_dat.delete();
        stale = mq_addr.size(); issue_pc = tgt; exp_next = tgt;
      end
      if (acc) begin
        mq_addr.push_back(issue_pc); mq_dat.push_back($urandom); mq_due.push_back(cyc + lat);
        issue_pc = issue_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    PC_sel = 1'b0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mq_dat[0];
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    case (rdy_mode)
      0: imem_req_ready = 1'b1;
      1: imem_req_ready = rdy_pat[cyc % 4];
      default: imem_req_ready = 1'($urandom_range(0, 1));
    endcase
    pipe_en = (pe_mode == 0) ? pe_fixed : 1'($urandom_range(0, 1));
  endtask

  task automatic defaults(int l);
    rdy_mode = 0; pe_mode = 0; pe_fixed = 1'b1; pipe_en = 1'b1; imem_req_ready = 1'b1; lat = l;
  endtask

  task automatic test_reset();
    defaults(1);
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC || valid_out !== 1'b0) begin
      bad++; $display("FAIL reset_release: req_valid=%b addr=%h valid=%b want 1 %h 0", imem_req_valid, imem_addr, valid_out, RST_PC);
    end
    cycle();
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL first_latency_early: valid_out=%b want 0", valid_out);
    end
    cycle();
    total++;
    if (valid_out !== 1'b1 || PC_out !== RST_PC || NPC4_out !== RST_PC + 32'd4) begin
      bad++; $display("FAIL first_word: valid=%b pc=%h npc4=%h want 1 %h %h", valid_out, PC_out, NPC4_out, RST_PC, RST_PC + 32'd4);
    end
    repeat (10) cycle();
  endtask

  task automatic test_stall();
    logic [31:0] held_pc, held_i;
    defaults(1);
    pe_fixed = 1'b0; pipe_en = 1'b0;
    cycle(); cycle();
    held_pc = PC_out; held_i = instr_out;
    repeat (3) cycle();
    total++;
    if (valid_out !== 1'b1 || PC_out !== held_pc || instr_out !== held_i) begin
      bad++; $display("FAIL stall_hold: valid=%b pc=%h instr=%h want 1 %h %h", valid_out, PC_out, instr_out, held_pc, held_i);
    end
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL stall_throttle: req_valid=%b want 0", imem_req_valid);
    end
    pe_fixed = 1'b1; pipe_en = 1'b1;
    cycle();
    total++;
    if (deliv_q[$] !== held_pc) begin
      bad++; $display("FAIL stall_resume: delivered %h want %h", deliv_q[$], held_pc);
    end
    repeat (10) cycle();
  endtask

  task automatic test_redirect_outstanding();
    bit found = 0;
    defaults(3);
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (mq_addr.size() == 2) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL redir_setup: outstanding never reached 2, want 2");
    end
    PC_sel = 1'b1; jPC = 32'h100;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (valid_out === 1'b1) found = 1;
    end
    total++;
    if (!found || PC_out !== 32'h100 || NPC4_out !== 32'h104) begin
      bad++; $display("FAIL redir_target: seen=%0d pc=%h npc4=%h want 1 100 104", found, PC_out, NPC4_out);
    end
    repeat (8) cycle();
  endtask

  task automatic test_rsp_redirect();
    bit found = 0;
    bit seen = 0;
    logic [31:0] bad_pc = '0;
    defaults(1);
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (imem_rsp_valid === 1'b1) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rsp_redir_setup: no response within 20 cycles, want one");
    end
    if (mq_addr.size() > 0) bad_pc = mq_addr[0];
    PC_sel = 1'b1; jPC = 32'h180;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (valid_out === 1'b1 && PC_out === bad_pc) seen = 1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rsp_redir_drop: word at %h delivered=%0d want 0", bad_pc, seen);
    end
  endtask

  task automatic test_double_redirect();
    bit found = 0;
    defaults(3);
    repeat (6) cycle();
    PC_sel = 1'b1; jPC = 32'h200;
    cycle();
    PC_sel = 1'b1; jPC = 32'h300;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (valid_out === 1'b1) found = 1;
    end
    total++;
    if (!found || PC_out !== 32'h300) begin
      bad++; $display("FAIL double_redir: seen=%0d pc=%h want 1 300", found, PC_out);
    end
    repeat (6) cycle();
  endtask

  task automatic test_ready_toggle();
    int d0;
    defaults(3);
    rdy_mode = 1;
    rst = 1'b1; cycle(); rst = 1'b0;
    d0 = n_deliv;
    repeat (48) cycle();
    total++;
    if (n_deliv - d0 < 5 || deliv_q[$] !== 32'(4 * (n_deliv - d0 - 1))) begin
      bad++; $display("FAIL ready_toggle: count=%0d last=%h want >=5 and last=%h",
                      n_deliv - d0, deliv_q[$], 32'(4 * (n_deliv - d0 - 1)));
    end
  endtask

  task automatic test_wrap();
    int d0;
    defaults(1);
    PC_sel = 1'b1; jPC = 32'hFFFF_FFFC;
    d0 = n_deliv;
    for (int i = 0; i < 30 && n_deliv < d0 + 2; i++) cycle();
    total++;
    if (n_deliv < d0 + 2) begin
      bad++; $display("FAIL wrap_timeout: delivered %0d want 2", n_deliv - d0);
    end else if (deliv_q[d0] !== 32'hFFFF_FFFC || deliv_q[d0 + 1] !== 32'h0) begin
      bad++; $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", deliv_q[d0], deliv_q[d0 + 1]);
    end
  endtask

  task automatic test_unaligned();
    int d0;
    defaults(2);
    PC_sel = 1'b1; jPC = 32'h102;
    d0 = n_deliv;
    for (int i = 0; i < 30 && n_deliv < d0 + 1; i++) cycle();
    total++;
    if (n_deliv < d0 + 1 || deliv_q[d0] !== 32'h100) begin
      bad++; $display("FAIL unaligned: count=%0d pc=%h want >=1 100", n_deliv - d0, deliv_q[$]);
    end
  endtask

  task automatic test_midstream_reset();
    int d0;
    defaults(2);
    repeat (7) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || instr_out !== 32'd0 || PC_out !== 32'd0 || NPC4_out !== 32'd0) begin
      bad++; $display("FAIL midrst_outputs: valid=%b instr=%h pc=%h npc4=%h want all 0", valid_out, instr_out, PC_out, NPC4_out);
    end
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      bad++; $display("FAIL midrst_pc: req_valid=%b addr=%h want 1 %h", imem_req_valid, imem_addr, RST_PC);
    end
    d0 = n_deliv;
    for (int i = 0; i < 20 && n_deliv < d0 + 1; i++) cycle();
    total++;
    if (n_deliv < d0 + 1 || deliv_q[d0] !== RST_PC) begin
      bad++; $display("FAIL midrst_restart: count=%0d pc=%h want >=1 %h", n_deliv - d0, deliv_q[$], RST_PC);
    end
  endtask

  task automatic test_random();
    int d0;
    defaults(2);
    rdy_mode = 2; pe_mode = 1;
    d0 = n_deliv;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 24) == 0) begin
        PC_sel = 1'b1; jPC = $urandom & 32'h0000_FFFF;
      end
      cycle();
    end
    total++;
    if (n_deliv - d0 < 20) begin
      bad++; $display("FAIL random_progress: delivered %0d want >=20", n_deliv - d0);
    end
    defaults(1);
    repeat (10) cycle();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_outstanding();
    test_rsp_redirect();
    test_double_redirect();
    test_ready_toggle();
    test_wrap();
    test_unaligned();
    test_midstream_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
